// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: datapath width, XZR index, ALUOp encodings,
// the EX control bundle and register-dependence helpers.
package legv8_pkg;

  localparam int XLEN = 64;
  localparam logic [4:0] XZR_IDX = 5'd31;

  typedef enum logic [1:0] {
    ALUOP_LDST  = 2'b00,
    ALUOP_CBZ   = 2'b01,
    ALUOP_RTYPE = 2'b10
  } aluop_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
  } ex_ctrl_t;

  // A producer matches a source only if it writes, and never through XZR.
  function automatic logic rd_matches(input logic wr, input logic [4:0] rd,
                                      input logic [4:0] src);
    return wr && (rd != XZR_IDX) && (rd == src);
  endfunction

  function automatic logic raw_dep(input logic wr, input logic [4:0] rd,
                                   input logic [4:0] rn, input logic [4:0] rm,
                                   input logic alu_src);
    return rd_matches(wr, rd, rn) || (rd_matches(wr, rd, rm) && !alu_src);
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Combinational operand bypass: EX/MEM result beats MEM/WB write data,
// which beats the value read from the register file.
module forwarding_unit #(
  parameter int XLEN = legv8_pkg::XLEN
) (
  input  logic [4:0]      src_idx,
  input  logic [XLEN-1:0] reg_value,
  input  logic            exmem_reg_write,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_value,
  input  logic            memwb_reg_write,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_value,
  output logic [XLEN-1:0] fwd_value
);
  import legv8_pkg::rd_matches;

  always_comb begin
    fwd_value = reg_value;
    if (rd_matches(exmem_reg_write, exmem_rd, src_idx)) begin
      fwd_value = exmem_value;
    end else if (rd_matches(memwb_reg_write, memwb_rd, src_idx)) begin
      fwd_value = memwb_value;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// LEGv8 ID/EX pipeline register with EX operand forwarding and load-use
// hazard detection. Forwarding is enabled by defining ID_EX_FORWARDING_EN.
module id_ex_stage #(
  parameter int XLEN = legv8_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [1:0]      id_ALUOp,
  input  logic [10:0]     id_Opcode,
  input  logic [XLEN-1:0] id_RegData1,
  input  logic [XLEN-1:0] id_RegData2,
  input  logic [XLEN-1:0] id_Imm,
  input  logic [4:0]      id_Rn,
  input  logic [4:0]      id_Rm,
  input  logic [4:0]      id_Rd,
  input  logic            id_ALUSrc,
  input  logic            id_RegWrite,
  input  logic            id_MemRead,
  input  logic            id_MemWrite,
  input  logic            id_MemtoReg,
  input  logic            stall,
  input  logic            flush,
  input  logic            exmem_RegWrite,
  input  logic [4:0]      exmem_Rd,
  input  logic [XLEN-1:0] exmem_ALU_Result,
  input  logic            memwb_RegWrite,
  input  logic [4:0]      memwb_Rd,
  input  logic [XLEN-1:0] memwb_WriteData,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [1:0]      ALUOp,
  output logic [10:0]     Opcode,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [XLEN-1:0] ex_StoreData,
  output logic [4:0]      ex_Rd,
  output logic            ex_RegWrite,
  output logic            ex_MemRead,
  output logic            ex_MemWrite,
  output logic            ex_MemtoReg
);
  import legv8_pkg::ex_ctrl_t;
  import legv8_pkg::raw_dep;

  logic            ex_valid_reg;
  ex_ctrl_t        ctrl_reg;
  logic [1:0]      alu_op_reg;
  logic [10:0]     opcode_reg;
  logic [XLEN-1:0] rd1_reg;
  logic [XLEN-1:0] rd2_reg;
  logic [XLEN-1:0] imm_reg;
  logic [4:0]      rn_reg;
  logic [4:0]      rm_reg;
  logic [XLEN-1:0] rn_fwd;
  logic [XLEN-1:0] rm_fwd;
  logic            hazard;

`ifdef ID_EX_FORWARDING_EN
  localparam logic FWD_EN = 1'b1;
  // Only a load in EX cannot be bypassed in time.
  assign hazard = id_valid &&
      raw_dep(ex_valid_reg && ctrl_reg.mem_read, ctrl_reg.rd, id_Rn, id_Rm, id_ALUSrc);
`else
  localparam logic FWD_EN = 1'b0;
  // Without bypass, wait until the producer reaches MEM/WB, where the register
  // file's write-before-read supplies the value.
  assign hazard = id_valid &&
      (raw_dep(ex_valid_reg && ctrl_reg.reg_write, ctrl_reg.rd, id_Rn, id_Rm, id_ALUSrc) ||
       raw_dep(exmem_RegWrite, exmem_Rd, id_Rn, id_Rm, id_ALUSrc));
`endif

  assign id_stall = !flush && (hazard || stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg <= 1'b0;
      ctrl_reg     <= '0;
      alu_op_reg   <= '0;
      opcode_reg   <= '0;
      rd1_reg      <= '0;
      rd2_reg      <= '0;
      imm_reg      <= '0;
      rn_reg       <= '0;
      rm_reg       <= '0;
    end else if (flush) begin
      ex_valid_reg <= 1'b0;
    end else if (stall) begin
      ex_valid_reg <= ex_valid_reg;
    end else if (hazard) begin
      ex_valid_reg <= 1'b0;
    end else begin
      ex_valid_reg        <= id_valid;
      ctrl_reg.rd         <= id_Rd;
      ctrl_reg.alu_src    <= id_ALUSrc;
      ctrl_reg.reg_write  <= id_RegWrite;
      ctrl_reg.mem_read   <= id_MemRead;
      ctrl_reg.mem_write  <= id_MemWrite;
      ctrl_reg.mem_to_reg <= id_MemtoReg;
      alu_op_reg          <= id_ALUOp;
      opcode_reg          <= id_Opcode;
      rd1_reg             <= id_RegData1;
      rd2_reg             <= id_RegData2;
      imm_reg             <= id_Imm;
      rn_reg              <= id_Rn;
      rm_reg              <= id_Rm;
    end
  end

  forwarding_unit #(.XLEN(XLEN)) u_fwd_rn (
    .src_idx         (rn_reg),
    .reg_value       (rd1_reg),
    .exmem_reg_write (exmem_RegWrite && FWD_EN),
    .exmem_rd        (exmem_Rd),
    .exmem_value     (exmem_ALU_Result),
    .memwb_reg_write (memwb_RegWrite && FWD_EN),
    .memwb_rd        (memwb_Rd),
    .memwb_value     (memwb_WriteData),
    .fwd_value       (rn_fwd)
  );

  forwarding_unit #(.XLEN(XLEN)) u_fwd_rm (
    .src_idx         (rm_reg),
    .reg_value       (rd2_reg),
    .exmem_reg_write (exmem_RegWrite && FWD_EN),
    .exmem_rd        (exmem_Rd),
    .exmem_value     (exmem_ALU_Result),
    .memwb_reg_write (memwb_RegWrite && FWD_EN),
    .memwb_rd        (memwb_Rd),
    .memwb_value     (memwb_WriteData),
    .fwd_value       (rm_fwd)
  );

  assign ex_valid     = ex_valid_reg;
  assign ALUOp        = alu_op_reg;
  assign Opcode       = opcode_reg;
  assign A            = rn_fwd;
  assign B            = ctrl_reg.alu_src ? imm_reg : rm_fwd;
  assign ex_StoreData = rm_fwd;
  assign ex_Rd        = ctrl_reg.rd;
  // A bubble must never write anything downstream.
  assign ex_RegWrite  = ex_valid_reg && ctrl_reg.reg_write;
  assign ex_MemRead   = ex_valid_reg && ctrl_reg.mem_read;
  assign ex_MemWrite  = ex_valid_reg && ctrl_reg.mem_write;
  assign ex_MemtoReg  = ex_valid_reg && ctrl_reg.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; covers both the default build and the
// ID_EX_FORWARDING_EN build.
module tb_id_ex_stage;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  logic [1:0]      id_ALUOp;
  logic [10:0]     id_Opcode;
  logic [XLEN-1:0] id_RegData1, id_RegData2, id_Imm;
  logic [4:0]      id_Rn, id_Rm, id_Rd;
  logic            id_ALUSrc, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg;
  logic            stall, flush;
  logic            exmem_RegWrite;
  logic [4:0]      exmem_Rd;
  logic [XLEN-1:0] exmem_ALU_Result;
  logic            memwb_RegWrite;
  logic [4:0]      memwb_Rd;
  logic [XLEN-1:0] memwb_WriteData;
  logic            id_stall, ex_valid;
  logic [1:0]      ALUOp;
  logic [10:0]     Opcode;
  logic [XLEN-1:0] A, B, ex_StoreData;
  logic [4:0]      ex_Rd;
  logic            ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] sub_val;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ALUOp(id_ALUOp),
    .id_Opcode(id_Opcode), .id_RegData1(id_RegData1), .id_RegData2(id_RegData2),
    .id_Imm(id_Imm), .id_Rn(id_Rn), .id_Rm(id_Rm), .id_Rd(id_Rd),
    .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg), .stall(stall),
    .flush(flush), .exmem_RegWrite(exmem_RegWrite), .exmem_Rd(exmem_Rd),
    .exmem_ALU_Result(exmem_ALU_Result), .memwb_RegWrite(memwb_RegWrite),
    .memwb_Rd(memwb_Rd), .memwb_WriteData(memwb_WriteData), .id_stall(id_stall),
    .ex_valid(ex_valid), .ALUOp(ALUOp), .Opcode(Opcode), .A(A), .B(B),
    .ex_StoreData(ex_StoreData), .ex_Rd(ex_Rd), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[%0t] check %s observed %h", $time, tag, obs);
  endtask

  task automatic drive_id(input logic [1:0] op, input logic [10:0] opc,
                          input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                          input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                          input logic alusrc, input logic rw, input logic mr);
    id_valid    = 1'b1;
    id_ALUOp    = op;
    id_Opcode   = opc;
    id_Rn       = rn;
    id_Rm       = rm;
    id_Rd       = rd;
    id_RegData1 = d1;
    id_RegData2 = d2;
    id_Imm      = imm;
    id_ALUSrc   = alusrc;
    id_RegWrite = rw;
    id_MemRead  = mr;
    id_MemWrite = 1'b0;
    id_MemtoReg = mr;
  endtask

  task automatic set_exmem(input logic rw, input logic [4:0] rd, input logic [63:0] v);
    exmem_RegWrite = rw; exmem_Rd = rd; exmem_ALU_Result = v;
  endtask

  task automatic set_memwb(input logic rw, input logic [4:0] rd, input logic [63:0] v);
    memwb_RegWrite = rw; memwb_Rd = rd; memwb_WriteData = v;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_exmem(1'b0, 5'd0, 64'h0);
    set_memwb(1'b0, 5'd0, 64'h0);
    // ADD X1, X2, X3 presented during reset
    drive_id(2'b10, 11'h458, 5'd2, 5'd3, 5'd1, 64'h20, 64'h30, 64'h0, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_opcode", {53'd0, Opcode}, 64'd0);
    chk("rst_aluop", {62'd0, ALUOp}, 64'd0);
    chk("rst_A", A, 64'd0);
    chk("rst_B", B, 64'd0);
    chk("rst_regwrite", {63'd0, ex_RegWrite}, 64'd0);
    chk("rst_id_stall", {63'd0, id_stall}, 64'd0);

    rst_n = 1'b1;
    tick();
    chk("add_ex_valid", {63'd0, ex_valid}, 64'd1);
    chk("add_opcode", {53'd0, Opcode}, 64'h458);
    chk("add_aluop", {62'd0, ALUOp}, 64'd2);
    chk("add_A", A, 64'h20);
    chk("add_B", B, 64'h30);
    chk("add_regwrite", {63'd0, ex_RegWrite}, 64'd1);
    chk("add_rd", {59'd0, ex_Rd}, 64'd1);

    // SUB X2, X1, X1 depends on the ADD in EX
    drive_id(2'b10, 11'h658, 5'd1, 5'd1, 5'd2, 64'hAA, 64'hAA, 64'h0, 1'b0, 1'b1, 1'b0);
    #1;
`ifdef ID_EX_FORWARDING_EN
    chk("raw_alu_no_stall", {63'd0, id_stall}, 64'd0);
    tick();
    chk("sub_ex_valid", {63'd0, ex_valid}, 64'd1);
    set_exmem(1'b1, 5'd1, 64'h50);
    #1;
    chk("fwd_exmem_A", A, 64'h50);
    chk("fwd_exmem_B", B, 64'h50);
    chk("fwd_exmem_store", ex_StoreData, 64'h50);
    set_memwb(1'b1, 5'd1, 64'h60);
    #1;
    chk("fwd_prio_exmem", A, 64'h50);
    set_exmem(1'b0, 5'd1, 64'h50);
    #1;
    chk("fwd_prio_memwb", A, 64'h60);
    set_exmem(1'b0, 5'd0, 64'h0);
    set_memwb(1'b0, 5'd0, 64'h0);
    #1;
    sub_val = 64'hAA;
`else
    chk("raw_stall_ex", {63'd0, id_stall}, 64'd1);
    tick();
    chk("bubble1_valid", {63'd0, ex_valid}, 64'd0);
    chk("bubble1_regwrite", {63'd0, ex_RegWrite}, 64'd0);
    set_exmem(1'b1, 5'd1, 64'h50);
    #1;
    chk("raw_stall_exmem", {63'd0, id_stall}, 64'd1);
    tick();
    chk("bubble2_valid", {63'd0, ex_valid}, 64'd0);
    set_exmem(1'b0, 5'd0, 64'h0);
    set_memwb(1'b1, 5'd1, 64'h50);
    id_RegData1 = 64'h50; id_RegData2 = 64'h50;
    #1;
    chk("raw_release", {63'd0, id_stall}, 64'd0);
    tick();
    set_memwb(1'b0, 5'd0, 64'h0);
    #1;
    chk("sub_ex_valid", {63'd0, ex_valid}, 64'd1);
    chk("sub_opcode", {53'd0, Opcode}, 64'h658);
    chk("sub_A", A, 64'h50);
    chk("sub_B", B, 64'h50);
    set_exmem(1'b1, 5'd1, 64'h77);
    #1;
    chk("nofwd_A", A, 64'h50);
    set_exmem(1'b0, 5'd0, 64'h0);
    #1;
    sub_val = 64'h50;
`endif

    // Downstream stall for three cycles with a new instruction waiting in ID
    drive_id(2'b10, 11'h458, 5'd2, 5'd3, 5'd1, 64'h21, 64'h31, 64'h0, 1'b0, 1'b1, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_opcode", {53'd0, Opcode}, 64'h658);
      chk("stall_A", A, sub_val);
      chk("stall_B", B, sub_val);
      chk("stall_id_stall", {63'd0, id_stall}, 64'd1);
    end
    stall = 1'b0;

    // LDUR X4, [X9, #8]
    drive_id(2'b00, 11'h7C2, 5'd9, 5'd0, 5'd4, 64'h1000, 64'h0, 64'h8, 1'b1, 1'b1, 1'b1);
    #1;
    chk("ldur_no_stall", {63'd0, id_stall}, 64'd0);
    tick();
    chk("ldur_opcode", {53'd0, Opcode}, 64'h7C2);
    chk("ldur_memread", {63'd0, ex_MemRead}, 64'd1);
    chk("ldur_A", A, 64'h1000);
    chk("ldur_B_imm", B, 64'h8);

    // ADD X5, X4, X6 after the load, with a flush on top
    drive_id(2'b10, 11'h458, 5'd4, 5'd6, 5'd5, 64'hBAD, 64'h6, 64'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("loaduse_stall", {63'd0, id_stall}, 64'd1);
    flush = 1'b1;
    #1;
    chk("flush_id_stall", {63'd0, id_stall}, 64'd0);
    tick();
    flush = 1'b0;
    chk("flush_ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("flush_memread", {63'd0, ex_MemRead}, 64'd0);

    // Load-use pair without flush
    drive_id(2'b00, 11'h7C2, 5'd9, 5'd0, 5'd4, 64'h1000, 64'h0, 64'h8, 1'b1, 1'b1, 1'b1);
    tick();
    drive_id(2'b10, 11'h458, 5'd4, 5'd6, 5'd5, 64'hBAD, 64'h6, 64'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("lu_stall", {63'd0, id_stall}, 64'd1);
    tick();
    chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
    set_exmem(1'b1, 5'd4, 64'h1008);
    #1;
`ifdef ID_EX_FORWARDING_EN
    chk("lu_one_bubble", {63'd0, id_stall}, 64'd0);
    tick();
    set_exmem(1'b0, 5'd0, 64'h0);
    set_memwb(1'b1, 5'd4, 64'hDEAD);
`else
    chk("lu_exmem_stall", {63'd0, id_stall}, 64'd1);
    tick();
    chk("lu_bubble2", {63'd0, ex_valid}, 64'd0);
    set_exmem(1'b0, 5'd0, 64'h0);
    set_memwb(1'b1, 5'd4, 64'hDEAD);
    id_RegData1 = 64'hDEAD;
    #1;
    chk("lu_release", {63'd0, id_stall}, 64'd0);
    tick();
`endif
    #1;
    chk("lu_ex_valid", {63'd0, ex_valid}, 64'd1);
    chk("lu_A", A, 64'hDEAD);
    chk("lu_B", B, 64'h6);
    chk("lu_store", ex_StoreData, 64'h6);
    set_memwb(1'b0, 5'd0, 64'h0);

`ifdef ID_EX_FORWARDING_EN
    // ADD X7, XZR, X3: XZR never forwarded, EX/MEM beats MEM/WB on Rm
    drive_id(2'b10, 11'h458, 5'd31, 5'd3, 5'd7, 64'h9, 64'h33, 64'h0, 1'b0, 1'b1, 1'b0);
    tick();
    set_exmem(1'b1, 5'd31, 64'h5);
    set_memwb(1'b1, 5'd31, 64'h6);
    #1;
    chk("xzr_A", A, 64'h9);
    set_exmem(1'b1, 5'd3, 64'h7);
    set_memwb(1'b1, 5'd3, 64'h8);
    #1;
    chk("prio_B_exmem", B, 64'h7);
    set_exmem(1'b0, 5'd3, 64'h7);
    #1;
    chk("prio_B_memwb", B, 64'h8);
    set_exmem(1'b0, 5'd0, 64'h0);
    set_memwb(1'b0, 5'd0, 64'h0);
    #1;
`endif

    // Reset mid-operation clears EX before any clock edge
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, ex_valid}, 64'd0);
    chk("async_rst_opcode", {53'd0, Opcode}, 64'd0);
    chk("async_rst_A", A, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
